// File: rtl/seg_bcd_scheduler.sv
// seg_bcd_scheduler: arbitrates CPU/switch loads, converts binary to BCD one bit per cycle,
// and drives a blanked, auto-paged 4-digit bus to the seven-segment scan driver.
module seg_bcd_scheduler #(
    parameter int PAGE_TICKS = 100_000_000,
    parameter bit LZ_BLANK   = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_req,
    input  logic [31:0] cpu_data,
    input  logic        sw_req,
    input  logic [15:0] sw_data,
    output logic        cpu_ack,
    output logic        sw_ack,
    output logic        busy,
    output logic        ovf,
    output logic        page,
    output logic [15:0] seg_data_16
);
    localparam int PW = PAGE_TICKS > 1 ? $clog2(PAGE_TICKS) : 1;
    typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;
    state_t state_q, state_d;
    logic [31:0] bin_q, bin_d, load_val, disp_q;
    logic [39:0] bcd_q, bcd_d, adj;
    logic [4:0] cnt_q;
    logic [PW-1:0] pcnt_q;
    logic ovf_pend_q, load;
    logic [7:0][3:0] dig;
    always_ff @(posedge clk or posedge rst)
        if (rst) state_q <= IDLE;
        else state_q <= state_d;
    always_comb
        state_d = state_q == IDLE ? ((cpu_req || sw_req) ? CONV : IDLE) :
                  state_q == CONV ? ((cnt_q == 5'd31) ? DONE : CONV) : IDLE;
    always_comb begin
        busy = state_q != IDLE;
        load = state_q == IDLE && (cpu_req || sw_req);
        load_val = cpu_req ? cpu_data : {16'd0, sw_data};
    end
    // One double-dabble step: correct each BCD nibble, then shift the whole {bcd,bin} pair
    always_comb begin
        adj = bcd_q;
        for (int i = 0; i < 10; i++)
            adj[4*i +: 4] = adj[4*i +: 4] >= 4'd5 ? adj[4*i +: 4] + 4'd3 : adj[4*i +: 4];
        {bcd_d, bin_d} = {adj, bin_q} << 1;
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            bin_q <= '0;
            bcd_q <= '0;
            cnt_q <= '0;
            ovf_pend_q <= 1'b0;
            disp_q <= '0;
            ovf <= 1'b0;
            cpu_ack <= 1'b0;
            sw_ack <= 1'b0;
            page <= 1'b0;
            pcnt_q <= '0;
        end else begin
            cpu_ack <= load && cpu_req;
            sw_ack <= load && !cpu_req;
            if (load) begin
                bin_q <= load_val;
                bcd_q <= '0;
                cnt_q <= '0;
                ovf_pend_q <= load_val > 32'd99_999_999;
            end else if (state_q == CONV) begin
                bin_q <= bin_d;
                bcd_q <= bcd_d;
                cnt_q <= cnt_q + 5'd1;
            end
            if (state_q == DONE) begin
                disp_q <= bcd_q[31:0];
                ovf <= ovf_pend_q;
                page <= 1'b0;
                pcnt_q <= '0;
            end else if (disp_q[31:16] == 16'd0 || ovf) begin
                page <= 1'b0;
                pcnt_q <= '0;
            end else if (pcnt_q == PW'(PAGE_TICKS - 1)) begin
                page <= ~page;
                pcnt_q <= '0;
            end else pcnt_q <= pcnt_q + 1'b1;
        end
    // A digit is blank only when it and every more significant digit are zero
    always_comb begin
        for (int i = 0; i < 8; i++)
            dig[i] = (LZ_BLANK && i > 0 && (disp_q >> (4 * i)) == 32'd0) ? 4'hF : disp_q[4*i +: 4];
        seg_data_16 = ovf ? 16'hFFFF : page ? dig[7:4] : dig[3:0];
    end
endmodule
